mem_stage_ctrl: RTL and testbench
=================================

// Module: mem_stage_ctrl
// PURPOSE
//  Consumer side of the EX/MEM pipeline register: takes the registered EX/MEM bundle, runs the
//  data-memory access over a req/ack handshake with variable latency, and stalls the front of
//  the pipe while the access is pending. Produces a registered MEM/WB bundle and an EX-stage
//  forwarding tap. Sits between EX_MEM and the data memory / MEM_WB logic of the 16-bit CPU.
// PARAMETERS
//  DATA_W   16  data and address width
//  REG_W    3   register-index width
//  TIMEOUT  15  REQ cycles without ack before abort (used only with MEM_TIMEOUT_EN)
// PORTS
//  clk           in   1       clock; all state updates on posedge
//  rst           in   1       reset, asynchronous, active-high
//  in_valid      in   1       EX/MEM slot holds a real instruction (0 = bubble)
//  alu_result_in in   DATA_W  ALU result; memory address for loads/stores
//  rd2_in        in   DATA_W  store data
//  rd_in         in   REG_W   destination register
//  mem_to_reg_in in   1       write-back selects memory data
//  reg_write_in  in   1       instruction writes the register file
//  mem_read_in   in   1       load
//  mem_write_in  in   1       store
//  stall_out     out  1       hold PC, IF/ID, ID/EX, EX/MEM this cycle (combinational)
//  dmem_req      out  1       memory request, held until ack
//  dmem_we       out  1       1 = write, 0 = read
//  dmem_addr     out  DATA_W  latched address
//  dmem_wdata    out  DATA_W  latched store data
//  dmem_ack      in   1       access complete; rdata valid in the same cycle
//  dmem_rdata    in   DATA_W  load data
//  wb_valid      out  1       MEM/WB slot valid (registered)
//  wb_reg_write  out  1       registered write enable
//  wb_rd         out  REG_W   registered destination
//  wb_data       out  DATA_W  registered write-back data
//  fwd_valid     out  1       combinational: EX may forward fwd_data for register fwd_rd
//  fwd_rd        out  REG_W   = rd_in
//  fwd_data      out  DATA_W  = alu_result_in
//  mem_err       out  1       one-cycle pulse on aborted access
// BEHAVIOUR
//  - Reset: state IDLE; dmem_req, dmem_we, wb_valid, wb_reg_write, mem_err = 0; dmem_addr,
//    dmem_wdata, wb_rd, wb_data = 0. A reset during REQ abandons the access; dmem_req drops at once.
//  - FSM IDLE/REQ. mem_op = in_valid & (mem_read_in | mem_write_in).
//  - IDLE, !mem_op: single-cycle pass-through. Next edge: wb_valid <= in_valid,
//    wb_reg_write <= in_valid & reg_write_in, wb_rd <= rd_in, wb_data <= alu_result_in. stall_out = 0.
//  - IDLE, mem_op: stall_out = 1; latch addr, wdata, rd, reg_write, mem_to_reg; dmem_we <= mem_write_in;
//    -> REQ with dmem_req = 1. wb_valid <= 0 (bubble).
//  - REQ: dmem_req stays 1 and addr/wdata/we stay stable until ack. stall_out = !dmem_ack.
//    No ack: wb_valid <= 0. Ack: dmem_req <= 0; -> IDLE; wb_valid <= 1; wb_reg_write <= latched
//    reg_write; wb_data <= mem_to_reg ? dmem_rdata : latched addr. Upstream advances on that edge.
//  - Latency: ALU op 1 cycle; memory op 1 + N cycles, where N >= 1 is the number of REQ cycles
//    up to and including ack. Minimum stall is 1 cycle.
//  - dmem_ack in IDLE is ignored. mem_read_in and mem_write_in both 1: treated as a store
//    (dmem_we = 1) and wb_data = addr.
//  - fwd_valid = in_valid & reg_write_in & !mem_read_in & (state == IDLE). Loads never forward from
//    this stage; the hazard unit must stall them.
// CONFIGURATION
//  MEM_TIMEOUT_EN defined: a 4-bit-min counter runs in REQ. After TIMEOUT REQ cycles without ack:
//    drop dmem_req, -> IDLE, pulse mem_err for 1 cycle, wb_valid <= 1 with wb_reg_write <= 0
//    (instruction squashed), stall_out = 0 in that cycle. An ack arriving in the same cycle wins.
//  MEM_TIMEOUT_EN undefined: REQ waits indefinitely; mem_err tied to 0; no counter logic.
// TESTING
//  1 ALU op: in_valid=1, reg_write=1, rd=3, alu=0x1234 -> next cycle wb_valid=1, wb_rd=3,
//    wb_data=0x1234; stall_out never 1.
//  2 Load, ack after 3 REQ cycles: addr=0x0040, rdata=0xBEEF -> stall_out=1 for 3 cycles,
//    dmem_req=1 for 3 cycles, then wb_data=0xBEEF, wb_reg_write=1.
//  3 Store, ack after 1 REQ cycle: addr=0x0010, rd2=0x00AA -> dmem_we=1, dmem_wdata=0x00AA,
//    one stall cycle, wb_reg_write=0.
//  4 Reset asserted in the 2nd REQ cycle -> dmem_req=0 immediately. After release, IDLE; a spurious
//    ack is ignored and wb_valid=0.
//  5 Back-to-back load then ALU op: the ALU op is presented only after the load ack. In-order
//    wb_valid pulses; fwd_valid=0 while the load sits in the stage.
//  6 (MEM_TIMEOUT_EN, TIMEOUT=15) no ack -> after 15 REQ cycles: mem_err pulse, dmem_req=0,
//    wb_reg_write=0, pipeline released.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: runs the data-memory req/ack access for the EX/MEM slot, stalls the front
// of the pipe while it is pending, and registers the MEM/WB bundle. Optional macro MEM_TIMEOUT_EN.
module mem_stage_ctrl #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 15
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] rd2_in,
    input  logic [REG_W-1:0]  rd_in,
    input  logic              mem_to_reg_in,
    input  logic              reg_write_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    output logic              stall_out,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [REG_W-1:0]  wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_rd,
    output logic [DATA_W-1:0] fwd_data,
    output logic              mem_err
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic             mem_op;
    logic             start_p0;
    logic             done_p1;
    logic             abort_p1;
    logic             expire;
    logic [REG_W-1:0] rd_p1;
    logic             reg_write_p1;
    logic             mem_to_reg_p1;

    assign mem_op = in_valid & (mem_read_in | mem_write_in);

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

    logic [CNT_W-1:0] req_cnt;

    // Counts completed REQ cycles; the TIMEOUT-th REQ cycle without ack aborts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_cnt <= '0;
        end else if (state == REQ) begin
            req_cnt <= req_cnt + 1'b1;
        end else begin
            req_cnt <= '0;
        end
    end

    assign expire = (req_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_err <= 1'b0;
        end else begin
            mem_err <= abort_p1;
        end
    end
`else
    assign expire  = 1'b0;
    assign mem_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // An ack in the expiry cycle completes normally rather than aborting.
    always_comb begin
        state_nxt = state;
        stall_out = 1'b0;
        start_p0  = 1'b0;
        done_p1   = 1'b0;
        abort_p1  = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    stall_out = 1'b1;
                    start_p0  = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (dmem_ack) begin
                    done_p1   = 1'b1;
                    state_nxt = IDLE;
                end else if (expire) begin
                    abort_p1  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    stall_out = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign dmem_req  = (state == REQ);
    assign fwd_valid = in_valid & reg_write_in & ~mem_read_in & (state == IDLE);
    assign fwd_rd    = rd_in;
    assign fwd_data  = alu_result_in;

    // Stage p0 -> p1: latch the access on entry to REQ
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_wdata    <= '0;
            rd_p1         <= '0;
            reg_write_p1  <= 1'b0;
            mem_to_reg_p1 <= 1'b0;
        end else if (start_p0) begin
            dmem_we       <= mem_write_in;
            dmem_addr     <= alu_result_in;
            dmem_wdata    <= rd2_in;
            rd_p1         <= rd_in;
            reg_write_p1  <= reg_write_in;
            mem_to_reg_p1 <= mem_to_reg_in & ~mem_write_in;
        end else if (done_p1 || abort_p1) begin
            dmem_we       <= 1'b0;
        end
    end

    // Stage p1 -> MEM/WB register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
        end else if (state == IDLE) begin
            if (mem_op) begin
                wb_valid     <= 1'b0;
                wb_reg_write <= 1'b0;
            end else begin
                wb_valid     <= in_valid;
                wb_reg_write <= in_valid & reg_write_in;
                wb_rd        <= rd_in;
                wb_data      <= alu_result_in;
            end
        end else if (done_p1) begin
            wb_valid     <= 1'b1;
            wb_reg_write <= reg_write_p1;
            wb_rd        <= rd_p1;
            wb_data      <= mem_to_reg_p1 ? dmem_rdata : dmem_addr;
        end else if (abort_p1) begin
            wb_valid     <= 1'b1;
            wb_reg_write <= 1'b0;
            wb_rd        <= rd_p1;
            wb_data      <= dmem_addr;
        end else begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: vector table for pass-through ops, hand sequences for memory
// corner cases, and randomized transactions against a per-instruction reference model.
module tb_mem_stage_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] alu_result_in;
    logic [15:0] rd2_in;
    logic [2:0]  rd_in;
    logic        mem_to_reg_in;
    logic        reg_write_in;
    logic        mem_read_in;
    logic        mem_write_in;
    logic        stall_out;
    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic        dmem_ack;
    logic [15:0] dmem_rdata;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic        fwd_valid;
    logic [2:0]  fwd_rd;
    logic [15:0] fwd_data;
    logic        mem_err;

    int checks = 0;
    int errors = 0;

    mem_stage_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .alu_result_in (alu_result_in),
        .rd2_in        (rd2_in),
        .rd_in         (rd_in),
        .mem_to_reg_in (mem_to_reg_in),
        .reg_write_in  (reg_write_in),
        .mem_read_in   (mem_read_in),
        .mem_write_in  (mem_write_in),
        .stall_out     (stall_out),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_ack      (dmem_ack),
        .dmem_rdata    (dmem_rdata),
        .wb_valid      (wb_valid),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .fwd_valid     (fwd_valid),
        .fwd_rd        (fwd_rd),
        .fwd_data      (fwd_data),
        .mem_err       (mem_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present one instruction (at posedge+1), act as the memory with an ack after n REQ
    // cycles, and check every cycle against what the instruction should produce.
    task automatic do_op(input logic v, input logic rw, input logic mtr, input logic mr,
                         input logic mw, input logic [2:0] rd, input logic [15:0] alu,
                         input logic [15:0] rd2, input int n, input logic [15:0] rdata,
                         input string tag);
        logic        is_mem;
        logic        exp_valid;
        logic        exp_rw;
        logic [15:0] exp_data;
        is_mem = v & (mr | mw);
        in_valid = v; reg_write_in = rw; mem_to_reg_in = mtr;
        mem_read_in = mr; mem_write_in = mw; rd_in = rd;
        alu_result_in = alu; rd2_in = rd2; dmem_ack = 1'b0;
        @(negedge clk);
        chk({tag, " stall_first"}, stall_out, is_mem);
        chk({tag, " fwd_valid"}, fwd_valid, v & rw & ~mr);
        chk({tag, " fwd_rd"}, fwd_rd, rd);
        chk({tag, " fwd_data"}, fwd_data, alu);
        chk({tag, " req_idle"}, dmem_req, 1'b0);
        if (is_mem) begin
            for (int k = 1; k <= n; k++) begin
                @(posedge clk); #1;
                dmem_ack   = (k == n);
                dmem_rdata = (k == n) ? rdata : 16'($urandom);
                @(negedge clk);
                chk({tag, " req"}, dmem_req, 1'b1);
                chk({tag, " we"}, dmem_we, mw);
                chk({tag, " addr"}, dmem_addr, alu);
                chk({tag, " wdata"}, dmem_wdata, rd2);
                chk({tag, " stall_req"}, stall_out, (k != n));
                chk({tag, " fwd_req"}, fwd_valid, 1'b0);
                chk({tag, " wb_bubble"}, wb_valid, 1'b0);
            end
            exp_valid = 1'b1;
            exp_rw    = rw;
            exp_data  = (mtr && !mw) ? rdata : alu;
        end else begin
            exp_valid = v;
            exp_rw    = v & rw;
            exp_data  = alu;
        end
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        chk({tag, " wb_valid"}, wb_valid, exp_valid);
        chk({tag, " wb_reg_write"}, wb_reg_write, exp_rw);
        chk({tag, " wb_rd"}, wb_rd, rd);
        chk({tag, " wb_data"}, wb_data, exp_data);
        chk({tag, " req_done"}, dmem_req, 1'b0);
        chk({tag, " mem_err"}, mem_err, 1'b0);
    endtask

    typedef struct {
        logic        v, rw, mtr, mr, mw;
        logic [2:0]  rd;
        logic [15:0] alu;
        logic        exp_wb_valid, exp_wb_rw, exp_fwd;
    } vec_t;

    vec_t tbl [8];

    initial begin
        tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 16'h1234, 1'b1, 1'b1, 1'b1};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 16'h5555, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 16'h0040, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd7, 16'h8000, 1'b1, 1'b1, 1'b1};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 16'hAAAA, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd6, 16'h7FFF, 1'b1, 1'b1, 1'b1};

        rst = 1'b1;
        in_valid = 1'b0; alu_result_in = '0; rd2_in = '0; rd_in = '0;
        mem_to_reg_in = 1'b0; reg_write_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
        dmem_ack = 1'b0; dmem_rdata = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst dmem_req", dmem_req, 1'b0);
        chk("rst dmem_we", dmem_we, 1'b0);
        chk("rst dmem_addr", dmem_addr, 16'h0);
        chk("rst dmem_wdata", dmem_wdata, 16'h0);
        chk("rst wb_valid", wb_valid, 1'b0);
        chk("rst wb_reg_write", wb_reg_write, 1'b0);
        chk("rst wb_rd", wb_rd, 3'd0);
        chk("rst wb_data", wb_data, 16'h0);
        chk("rst mem_err", mem_err, 1'b0);
        chk("rst stall", stall_out, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Pass-through vectors
        for (int i = 0; i < 8; i++) begin
            in_valid = tbl[i].v; reg_write_in = tbl[i].rw; mem_to_reg_in = tbl[i].mtr;
            mem_read_in = tbl[i].mr; mem_write_in = tbl[i].mw; rd_in = tbl[i].rd;
            alu_result_in = tbl[i].alu; rd2_in = 16'h0BAD;
            @(negedge clk);
            chk($sformatf("vec%0d stall", i), stall_out, 1'b0);
            chk($sformatf("vec%0d fwd_valid", i), fwd_valid, tbl[i].exp_fwd);
            chk($sformatf("vec%0d dmem_req", i), dmem_req, 1'b0);
            @(posedge clk); #1;
            chk($sformatf("vec%0d wb_valid", i), wb_valid, tbl[i].exp_wb_valid);
            chk($sformatf("vec%0d wb_reg_write", i), wb_reg_write, tbl[i].exp_wb_rw);
            chk($sformatf("vec%0d wb_rd", i), wb_rd, tbl[i].rd);
            chk($sformatf("vec%0d wb_data", i), wb_data, tbl[i].alu);
        end

        // Load with ack on the 3rd REQ cycle
        do_op(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 16'h0040, 16'h0000, 3, 16'hBEEF, "load3");
        chk("load3 data const", wb_data, 16'hBEEF);
        chk("load3 rw const", wb_reg_write, 1'b1);

        // Store with ack on the first REQ cycle
        do_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 16'h0010, 16'h00AA, 1, 16'h1111, "store1");
        chk("store1 rw const", wb_reg_write, 1'b0);
        chk("store1 data const", wb_data, 16'h0010);

        // Read and write both set: store semantics, address written back
        do_op(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd6, 16'h0123, 16'h4567, 2, 16'hDEAD, "both");

        // Load followed by an ALU op presented after the ack
        do_op(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd4, 16'h0200, 16'h0000, 2, 16'hCAFE, "b2b_ld");
        do_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 16'h0F0F, 16'h0000, 1, 16'h0000, "b2b_alu");

        // Store that writes a register forwards in IDLE only
        do_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 16'h0030, 16'h0055, 2, 16'h0000, "st_fwd");

        // Reset in the 2nd REQ cycle, then a spurious ack
        in_valid = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b0; reg_write_in = 1'b1;
        mem_to_reg_in = 1'b1; rd_in = 3'd5; alu_result_in = 16'h0100; dmem_ack = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstreq req1", dmem_req, 1'b1);
        @(posedge clk); #1;
        chk("rstreq req2", dmem_req, 1'b1);
        rst = 1'b1;
        #1;
        chk("rstreq req_drop", dmem_req, 1'b0);
        chk("rstreq wb_valid", wb_valid, 1'b0);
        in_valid = 1'b0; mem_read_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        dmem_ack = 1'b1;
        @(negedge clk);
        chk("rstreq idle req", dmem_req, 1'b0);
        chk("rstreq idle stall", stall_out, 1'b0);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        chk("spurious ack wb_valid", wb_valid, 1'b0);
        chk("spurious ack req", dmem_req, 1'b0);

`ifdef MEM_TIMEOUT_EN
        // No ack: abort after 15 REQ cycles
        in_valid = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b0; reg_write_in = 1'b1;
        mem_to_reg_in = 1'b1; rd_in = 3'd7; alu_result_in = 16'h0300; dmem_ack = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("tmo req%0d", k), dmem_req, 1'b1);
            chk($sformatf("tmo stall%0d", k), stall_out, (k != 15));
        end
        @(posedge clk); #1;
        in_valid = 1'b0; mem_read_in = 1'b0;
        chk("tmo mem_err", mem_err, 1'b1);
        chk("tmo req_drop", dmem_req, 1'b0);
        chk("tmo wb_valid", wb_valid, 1'b1);
        chk("tmo wb_reg_write", wb_reg_write, 1'b0);
        @(posedge clk); #1;
        chk("tmo mem_err_pulse", mem_err, 1'b0);
`endif

        // Randomized instruction stream
        for (int i = 0; i < 60; i++) begin
            int          kind;
            logic        v, rw, mtr, mr, mw;
            kind = $urandom_range(0, 4);
            v    = (kind != 0);
            rw   = 1'($urandom_range(0, 1));
            mtr  = 1'($urandom_range(0, 1));
            mr   = (kind == 2) || (kind == 4);
            mw   = (kind == 3) || (kind == 4);
            if (kind == 0) begin
                mr = 1'($urandom_range(0, 1));
                mw = 1'($urandom_range(0, 1));
            end
            if (kind == 3) mtr = 1'b0;
            do_op(v, rw, mtr, mr, mw, 3'($urandom_range(0, 7)), 16'($urandom),
                  16'($urandom), $urandom_range(1, 4), 16'($urandom),
                  $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
